m_lsu_ctrl: RTL and testbench

M_LSU_CTRL -- requirements
Module: m_lsu_ctrl

---
 rtl/m_lsu_ctrl_if.sv | 16 +
 rtl/m_lsu_ctrl.sv | 118 +++++++++++
 tb/tb_m_lsu_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/m_lsu_ctrl_if.sv
// Data-bus handshake between the load/store controller (master) and the memory port (slave).
interface m_lsu_ctrl_if #(parameter int XLEN = 32);
   logic            dbus_req_o;
   logic            dbus_we_o;
   logic [XLEN-1:0] dbus_addr_o;
   logic [XLEN-1:0] dbus_wdata_o;
   logic [3:0]      dbus_be_o;
   logic            dbus_gnt_i;
   logic            dbus_rvalid_i;
   logic [XLEN-1:0] dbus_rdata_i;

   modport master (output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
                   input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i);
   modport slave  (input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
                   output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i);
endinterface

// File: rtl/m_lsu_ctrl.sv
// Single-outstanding load/store controller: accepts one EXE/MEM op, runs the data-bus
// req/gnt/rvalid handshake, extends load data, and drains responses of flushed ops.
module m_lsu_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_mem_valid_i,
   input  logic            ex_mem_we_i,
   input  logic [2:0]      ex_mem_funct3_i,
   input  logic [XLEN-1:0] ex_mem_addr_i,
   input  logic [XLEN-1:0] ex_mem_wdata_i,
   input  logic [4:0]      ex_mem_rd_i,
   input  logic            lsu_flush_i,
   m_lsu_ctrl_if.master    dbus,
   output logic            lsu_req_o,
   output logic            lsu_ack_o,
   output logic [XLEN-1:0] lsu_rdata_o,
   output logic [4:0]      lsu_rd_o,
   output logic            lsu_misalign_o,
   output logic            lsu_busy_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

   state_t          state, state_nxt;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:2] addr_q;
   logic [1:0]      off_q;
   logic [4:0]      rd_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;

   logic            illegal, misalign, bad, accept;
   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d;
   logic [XLEN-1:0] rd_shift, load_ext;

   // Decode of the op presented in IDLE; size lives in funct3[1:0], sign in funct3[2].
   always_comb begin
      illegal  = (ex_mem_funct3_i == 3'b011) || (ex_mem_funct3_i[2:1] == 2'b11);
      misalign = ((ex_mem_funct3_i[1:0] == 2'b01) && ex_mem_addr_i[0]) ||
                 ((ex_mem_funct3_i[1:0] == 2'b10) && (ex_mem_addr_i[1:0] != 2'b00));
      bad      = illegal || misalign;
      accept   = rst_n && (state == IDLE) && ex_mem_valid_i && !lsu_flush_i && !bad;
      case (ex_mem_funct3_i[1:0])
         2'b00:   begin be_d = 4'b0001 << ex_mem_addr_i[1:0];
                        wdata_d = {4{ex_mem_wdata_i[7:0]}}; end
         2'b01:   begin be_d = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{ex_mem_wdata_i[15:0]}}; end
         default: begin be_d = 4'b1111;
                        wdata_d = ex_mem_wdata_i; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q <= 1'b0; f3_q <= '0; addr_q <= '0; off_q <= '0;
         rd_q <= '0;   be_q <= '0; wdata_q <= '0;
      end else if (accept) begin
         we_q    <= ex_mem_we_i;
         f3_q    <= ex_mem_funct3_i;
         addr_q  <= ex_mem_addr_i[XLEN-1:2];
         off_q   <= ex_mem_addr_i[1:0];
         rd_q    <= ex_mem_rd_i;
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = REQ;
         REQ:   if (lsu_flush_i) state_nxt = dbus.dbus_gnt_i ? DRAIN : IDLE;
                else if (dbus.dbus_gnt_i) state_nxt = WAIT;
         WAIT:  if (dbus.dbus_rvalid_i) state_nxt = IDLE;
                else if (lsu_flush_i) state_nxt = DRAIN;
         DRAIN: if (dbus.dbus_rvalid_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lane select and extension of the returned word.
   always_comb begin
      rd_shift = dbus.dbus_rdata_i >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  load_ext = {24'd0, rd_shift[7:0]};
         3'b001:  load_ext = off_q[1] ? {{16{dbus.dbus_rdata_i[31]}}, dbus.dbus_rdata_i[31:16]}
                                      : {{16{dbus.dbus_rdata_i[15]}}, dbus.dbus_rdata_i[15:0]};
         3'b101:  load_ext = off_q[1] ? {16'd0, dbus.dbus_rdata_i[31:16]}
                                      : {16'd0, dbus.dbus_rdata_i[15:0]};
         default: load_ext = dbus.dbus_rdata_i;
      endcase
   end

   always_comb begin
      dbus.dbus_req_o   = (state == REQ);
      dbus.dbus_we_o    = we_q;
      dbus.dbus_addr_o  = {addr_q, 2'b00};
      dbus.dbus_be_o    = be_q;
      dbus.dbus_wdata_o = wdata_q;
      lsu_req_o         = accept;
      lsu_misalign_o    = rst_n && (state == IDLE) && ex_mem_valid_i && !lsu_flush_i && bad;
      lsu_ack_o         = rst_n && (state == WAIT) && dbus.dbus_rvalid_i && !lsu_flush_i;
      lsu_rdata_o       = (lsu_ack_o && !we_q) ? load_ext : '0;
      lsu_rd_o          = (lsu_ack_o && !we_q) ? rd_q : 5'd0;
      lsu_busy_o        = (state != IDLE);
   end

endmodule

// File: tb/tb_m_lsu_ctrl.sv
// Directed bench for m_lsu_ctrl: loads of every size, stalled store, misalign, flush and reset cases.
module tb_m_lsu_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, we, flush;
   logic [2:0]  f3;
   logic [31:0] addr, wdata;
   logic [4:0]  rd;
   logic        lsu_req, lsu_ack, lsu_mis, lsu_busy;
   logic [31:0] lsu_rdata;
   logic [4:0]  lsu_rd;
   int          n_tests = 0;
   int          n_fail  = 0;

   m_lsu_ctrl_if #(.XLEN(32)) dbus ();

   m_lsu_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_mem_valid_i(valid), .ex_mem_we_i(we), .ex_mem_funct3_i(f3),
      .ex_mem_addr_i(addr), .ex_mem_wdata_i(wdata), .ex_mem_rd_i(rd),
      .lsu_flush_i(flush), .dbus(dbus.master),
      .lsu_req_o(lsu_req), .lsu_ack_o(lsu_ack), .lsu_rdata_o(lsu_rdata),
      .lsu_rd_o(lsu_rd), .lsu_misalign_o(lsu_mis), .lsu_busy_o(lsu_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs are then driven at the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_in();
      valid = 0; we = 0; f3 = 0; addr = 0; wdata = 0; rd = 0; flush = 0;
      dbus.dbus_gnt_i = 0; dbus.dbus_rvalid_i = 0; dbus.dbus_rdata_i = 0;
   endtask

   task automatic present(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r);
      valid = 1; we = w; f3 = f; addr = a; wdata = d; rd = r;
   endtask

   // Accept, grant in the first REQ cycle, rvalid the next: the minimum-latency path.
   task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] raw, input logic [3:0] ebe, input logic [31:0] exp);
      present(0, f, a, 32'h0, 5'd7);
      #1 chk({tag, " req"}, lsu_req, 1);
      cyc();
      valid = 0; dbus.dbus_gnt_i = 1;
      #1 chk({tag, " dreq"}, dbus.dbus_req_o, 1);
      chk({tag, " addr"}, dbus.dbus_addr_o, {a[31:2], 2'b00});
      chk({tag, " be"}, dbus.dbus_be_o, ebe);
      chk({tag, " ack0"}, lsu_ack, 0);
      cyc();
      dbus.dbus_gnt_i = 0; dbus.dbus_rvalid_i = 1; dbus.dbus_rdata_i = raw;
      #1 chk({tag, " ack"}, lsu_ack, 1);
      chk({tag, " rdata"}, lsu_rdata, exp);
      chk({tag, " rd"}, lsu_rd, 7);
      chk({tag, " noreq"}, lsu_req, 0);
      cyc();
      dbus.dbus_rvalid_i = 0;
   endtask

   initial begin
      idle_in();
      rst_n = 0;
      @(negedge clk);
      present(0, 3'b010, 32'h100, 0, 1);
      #1 chk("rst lsu_req", lsu_req, 0);
      cyc();
      #1 chk("rst busy", lsu_busy, 0);
      chk("rst dreq", dbus.dbus_req_o, 0);
      chk("rst ack", lsu_ack, 0);
      chk("rst mis", lsu_mis, 0);
      chk("rst be", dbus.dbus_be_o, 0);
      idle_in();
      rst_n = 1;
      cyc();

      // Back-to-back loads over all sizes and extensions.
      do_load("LB",  3'b000, 32'h1003, 32'h80FF_FF00, 4'b1000, 32'hFFFF_FF80);
      do_load("LBU", 3'b100, 32'h1001, 32'h1234_8F56, 4'b0010, 32'h0000_008F);
      do_load("LH",  3'b001, 32'h1002, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
      do_load("LHU", 3'b101, 32'h1000, 32'h0000_F00D, 4'b0011, 32'h0000_F00D);
      do_load("LW",  3'b010, 32'h1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      // SH with grant held low for 3 cycles.
      present(1, 3'b001, 32'h2002, 32'h0000_ABCD, 5'd3);
      #1 chk("SH req", lsu_req, 1);
      cyc();
      valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("SH dreq held", dbus.dbus_req_o, 1);
         chk("SH be", dbus.dbus_be_o, 4'b1100);
         chk("SH wdata", dbus.dbus_wdata_o, 32'hABCD_ABCD);
         chk("SH we", dbus.dbus_we_o, 1);
         chk("SH addr", dbus.dbus_addr_o, 32'h2000);
         cyc();
      end
      dbus.dbus_gnt_i = 1;
      #1 chk("SH dreq gnt", dbus.dbus_req_o, 1);
      cyc();
      dbus.dbus_gnt_i = 0; dbus.dbus_rvalid_i = 1; dbus.dbus_rdata_i = 32'h5555_5555;
      #1 chk("SH ack", lsu_ack, 1);
      chk("SH rdata", lsu_rdata, 0);
      cyc();
      dbus.dbus_rvalid_i = 0;
      #1 chk("SH idle", lsu_busy, 0);

      // Misaligned and illegal ops; misalign masked by flush.
      present(0, 3'b010, 32'h3001, 0, 2);
      #1 chk("LW mis", lsu_mis, 1);
      chk("LW mis req", lsu_req, 0);
      chk("LW mis dreq", dbus.dbus_req_o, 0);
      cyc();
      #1 chk("LW mis busy", lsu_busy, 0);
      present(0, 3'b001, 32'h3003, 0, 2);
      #1 chk("LH mis", lsu_mis, 1);
      f3 = 3'b011; addr = 32'h3000;
      #1 chk("f3 011 mis", lsu_mis, 1);
      f3 = 3'b110;
      #1 chk("f3 110 mis", lsu_mis, 1);
      f3 = 3'b010; addr = 32'h3002; flush = 1;
      #1 chk("mis flush", lsu_mis, 0);
      addr = 32'h3000;
      #1 chk("idle flush req", lsu_req, 0);
      cyc();
      #1 chk("idle flush busy", lsu_busy, 0);
      idle_in();

      // LHU flushed in WAIT, response two cycles later is drained.
      present(0, 3'b101, 32'h4002, 0, 4);
      cyc();
      valid = 0; dbus.dbus_gnt_i = 1;
      cyc();
      dbus.dbus_gnt_i = 0; flush = 1;
      #1 chk("WAIT flush ack", lsu_ack, 0);
      cyc();
      flush = 0;
      #1 chk("DRAIN busy", lsu_busy, 1);
      cyc();
      dbus.dbus_rvalid_i = 1;
      #1 chk("DRAIN ack", lsu_ack, 0);
      cyc();
      dbus.dbus_rvalid_i = 0;
      #1 chk("DRAIN done", lsu_busy, 0);

      // Flush together with grant; a new op during DRAIN is not accepted.
      present(0, 3'b010, 32'h5000, 0, 6);
      cyc();
      valid = 0; dbus.dbus_gnt_i = 1; flush = 1;
      cyc();
      dbus.dbus_gnt_i = 0; flush = 0;
      present(0, 3'b010, 32'h6000, 0, 6);
      #1 chk("DRAIN2 req", lsu_req, 0);
      chk("DRAIN2 dreq", dbus.dbus_req_o, 0);
      chk("DRAIN2 busy", lsu_busy, 1);
      cyc();
      valid = 0; dbus.dbus_rvalid_i = 1;
      #1 chk("DRAIN2 ack", lsu_ack, 0);
      cyc();
      dbus.dbus_rvalid_i = 0;
      #1 chk("DRAIN2 done", lsu_busy, 0);

      // Flush in REQ without grant drops the request.
      present(0, 3'b000, 32'h7001, 0, 1);
      cyc();
      valid = 0; flush = 1;
      cyc();
      flush = 0;
      #1 chk("REQ flush dreq", dbus.dbus_req_o, 0);
      chk("REQ flush busy", lsu_busy, 0);

      // Flush coinciding with rvalid suppresses the ack.
      present(0, 3'b000, 32'h7000, 0, 1);
      cyc();
      valid = 0; dbus.dbus_gnt_i = 1;
      cyc();
      dbus.dbus_gnt_i = 0; dbus.dbus_rvalid_i = 1; flush = 1;
      #1 chk("WAIT rv flush ack", lsu_ack, 0);
      cyc();
      idle_in();
      #1 chk("WAIT rv flush busy", lsu_busy, 0);

      // Reset while in WAIT; a late rvalid is ignored.
      present(0, 3'b010, 32'h8000, 0, 9);
      cyc();
      valid = 0; dbus.dbus_gnt_i = 1;
      cyc();
      dbus.dbus_gnt_i = 0; rst_n = 0;
      cyc();
      rst_n = 1; dbus.dbus_rvalid_i = 1; dbus.dbus_rdata_i = 32'h1234_5678;
      #1 chk("rstW busy", lsu_busy, 0);
      chk("rstW ack", lsu_ack, 0);
      chk("rstW dreq", dbus.dbus_req_o, 0);
      chk("rstW rdata", lsu_rdata, 0);
      chk("rstW be", dbus.dbus_be_o, 0);
      cyc();
      idle_in();
      #1 chk("rstW idle", lsu_busy, 0);

      // Normal operation resumes after the abandoned op.
      do_load("LB post", 3'b000, 32'h9000, 32'h0000_007F, 4'b0001, 32'h0000_007F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
